// File: rtl/demux_1to2_pair.sv
// demux_1to2_pair: steers sel-tagged beats into a word pair with a valid/ready output.
// Optional err_cnt output and counter under `DEMUX_PAIR_ERRCNT_EN.
module demux_1to2_pair #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  input  logic             sel,
  input  logic             inp_valid,
  output logic             inp_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef DEMUX_PAIR_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             err
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    LOW   = 2'b01,
    FULL  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             err_q, err_d;
  logic             acc;

  // Ready depends only on state and downstream ready
  always_comb begin
    inp_ready = 1'b0;
    case (state_q)
      EMPTY:   inp_ready = 1'b1;
      LOW:     inp_ready = 1'b1;
      FULL:    inp_ready = out_ready;
      default: inp_ready = 1'b0;
    endcase
  end

  assign acc       = inp_valid & inp_ready;
  assign out_valid = (state_q == FULL);
  assign out0      = out0_q;
  assign out1      = out1_q;
  assign err       = err_q;

  // Next state, word steering and order-error detection
  always_comb begin
    state_d = state_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    err_d   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          if (!sel) begin
            out0_d  = inp;
            state_d = LOW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOW: begin
        if (acc) begin
          if (sel) begin
            out1_d  = inp;
            state_d = FULL;
          end else begin
            out0_d = inp;
            err_d  = 1'b1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = EMPTY;
          if (acc) begin
            if (!sel) begin
              out0_d  = inp;
              state_d = LOW;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out0_q  <= '0;
      out1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      err_q   <= err_d;
    end
  end

`ifdef DEMUX_PAIR_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating count of error pulses, advancing with err
  always_comb begin
    cnt_d = cnt_q;
    if (err_d && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`endif

endmodule
